cnt_display: RTL and testbench

Downstream display stage for the 20-bit prime-count value `cnt_20b` produced by the counting stage. It captures the count on an update strobe, converts it to 7 BCD digits with a sequential shift-and-add-3 (double-dabble) engine, and drives a multiplexed 8-digit active-low seven-segment display with leading-zero blanking. It sits between the counting stage and the board's segment/anode pins.

---
 rtl/cnt_display_if.sv | 14 +
 rtl/cnt_display.sv | 167 ++++++++++++++++
 tb/tb_cnt_display.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cnt_display_if.sv
// Bundles the update request, conversion status, BCD result and display pins of cnt_display.
`timescale 1ns/1ps
interface cnt_display_if;
  logic        upd;
  logic [19:0] value;
  logic        busy;
  logic        done;
  logic [27:0] digits;
  logic [7:0]  an;
  logic [7:0]  seg;

  modport master (output upd, value, input busy, done, digits, an, seg);
  modport slave  (input upd, value, output busy, done, digits, an, seg);
endinterface

// File: rtl/cnt_display.sv
// This block captures a 20-bit count and converts it to 7 BCD digits, one bit per clock,
// using the shift-and-add-3 (double-dabble) method. It also scans an 8-digit active-low
// seven-segment display and blanks leading zeros.
//
// state | meaning
// IDLE  | no conversion running; the block waits for upd
// CONV  | shift-and-add-3 running, 20 cycles per value
`timescale 1ns/1ps
module cnt_display #(
  parameter int SCAN_DIV = 100000
) (
  input logic         clk,
  input logic         rst,
  cnt_display_if.slave bus
);

  localparam int CW = $clog2(SCAN_DIV);

  typedef enum logic {IDLE, CONV} state_t;

  state_t        state, state_n;
  logic [19:0]   bin, bin_sh;
  logic [27:0]   bcd, bcd_adj, bcd_sh;
  logic [4:0]    iter;
  logic          pend;
  logic [19:0]   pend_val;
  logic          last, start;
  logic [19:0]   start_val;
  logic          done_r;
  logic [27:0]   digits_r;

  logic [CW-1:0] scan_cnt;
  logic [2:0]    idx, idx_n;
  logic [7:0]    blank;
  logic [31:0]   digit_vec;
  logic [7:0]    an_r, seg_r, seg_n;

  function automatic logic [7:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    enc = 8'hC0;
      4'd1:    enc = 8'hF9;
      4'd2:    enc = 8'hA4;
      4'd3:    enc = 8'hB0;
      4'd4:    enc = 8'h99;
      4'd5:    enc = 8'h92;
      4'd6:    enc = 8'h82;
      4'd7:    enc = 8'hF8;
      4'd8:    enc = 8'h80;
      4'd9:    enc = 8'h90;
      default: enc = 8'hFF;
    endcase
  endfunction

  // Add 3 to every BCD nibble that is 5 or more, then shift the {bcd, bin} pair left by one bit.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 7; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    {bcd_sh, bin_sh} = {bcd_adj, bin} << 1;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic and the restart decision. On the final cycle an upd in that same cycle
  // is the newest value, so it takes priority over the stored pending value.
  always_comb begin
    state_n   = state;
    start     = 1'b0;
    start_val = bus.value;
    last      = (state == CONV) && (iter == 5'd19);
    case (state)
      IDLE: begin
        if (bus.upd) begin
          start   = 1'b1;
          state_n = CONV;
        end
      end
      CONV: begin
        if (last) begin
          if (bus.upd) begin
            start = 1'b1;
          end else if (pend) begin
            start     = 1'b1;
            start_val = pend_val;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Conversion datapath, pending-value capture and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin      <= '0;
      bcd      <= '0;
      iter     <= '0;
      pend     <= 1'b0;
      pend_val <= '0;
      done_r   <= 1'b0;
      digits_r <= '0;
    end else begin
      done_r <= 1'b0;
      if (last) begin
        digits_r <= bcd_sh;
        done_r   <= 1'b1;
        pend     <= 1'b0;
      end else if (state == CONV && bus.upd) begin
        pend     <= 1'b1;
        pend_val <= bus.value;
      end
      if (start) begin
        bin  <= start_val;
        bcd  <= '0;
        iter <= '0;
      end else if (state == CONV) begin
        bin  <= bin_sh;
        bcd  <= bcd_sh;
        iter <= iter + 5'd1;
      end
    end
  end

  // Leading-zero blanking. Digit 7 is always blank. Digit 0 is never blank.
  always_comb begin
    logic nz;
    nz        = 1'b0;
    blank     = 8'h80;
    digit_vec = {4'h0, digits_r};
    for (int i = 6; i >= 0; i--) begin
      nz       = nz | (digits_r[4*i +: 4] != 4'd0);
      blank[i] = !nz && (i != 0);
    end
    idx_n = (scan_cnt == CW'(SCAN_DIV - 1)) ? idx + 3'd1 : idx;
    seg_n = blank[idx_n] ? 8'hFF : enc(digit_vec[4*idx_n +: 4]);
  end

  // Scan timer, digit index and registered display pins. an and seg follow the next index
  // together, so both pins always describe the same digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= '0;
      an_r     <= 8'hFE;
      seg_r    <= 8'hC0;
    end else begin
      scan_cnt <= (scan_cnt == CW'(SCAN_DIV - 1)) ? '0 : scan_cnt + CW'(1);
      idx      <= idx_n;
      an_r     <= ~(8'd1 << idx_n);
      seg_r    <= seg_n;
    end
  end

  assign bus.busy   = (state == CONV);
  assign bus.done   = done_r;
  assign bus.digits = digits_r;
  assign bus.an     = an_r;
  assign bus.seg    = seg_r;

endmodule

// File: tb/tb_cnt_display.sv
// Testbench for cnt_display. It uses SCAN_DIV=4 and a queue of expected BCD results that is
// checked on every done pulse.
`timescale 1ns/1ps
module tb_cnt_display;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;
  logic [27:0] exp_q[$];

  cnt_display_if dif();

  cnt_display #(.SCAN_DIV(4)) dut (.clk(clk), .rst(rst), .bus(dif));

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  function automatic logic [27:0] to_bcd(input int v);
    logic [27:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < 7; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Compare every done pulse against the oldest expected result.
  always @(negedge clk) begin
    if (!rst && dif.done === 1'b1) begin
      done_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: digits=%h, no result expected", dif.digits);
      end else begin
        logic [27:0] e;
        e = exp_q.pop_front();
        if (dif.digits !== e) begin
          errors++;
          $display("FAIL done_digits: got %h expected %h", dif.digits, e);
        end
      end
    end
  end

  task automatic drive_upd(input logic [19:0] v);
    @(posedge clk); #1;
    dif.upd = 1'b1; dif.value = v;
    @(posedge clk); #1;
    dif.upd = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (dif.done === 1'b1) begin ok = 1; break; end
    end
  endtask

  task automatic wait_slot(input int d, output bit ok);
    logic [7:0] tgt;
    tgt = ~(8'd1 << d);
    ok = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (dif.an === tgt) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; dif.upd = 1'b0; dif.value = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (dif.busy !== 1'b0 || dif.done !== 1'b0 || dif.digits !== 28'h0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b done=%b digits=%h expected 0 0 0000000", dif.busy, dif.done, dif.digits);
    end
    checks++;
    if (dif.an !== 8'hFE || dif.seg !== 8'hC0) begin
      errors++;
      $display("FAIL reset_disp: an=%h seg=%h expected FE C0", dif.an, dif.seg);
    end
    rst = 1'b0;
  endtask

  task automatic test_scan;
    logic [7:0] ea;
    checks++;
    if (dif.an !== 8'hFE || dif.seg !== 8'hC0) begin
      errors++;
      $display("FAIL scan_slot0: an=%h seg=%h expected FE C0", dif.an, dif.seg);
    end
    for (int k = 1; k < 8; k++) begin
      repeat (4) @(posedge clk);
      @(negedge clk);
      ea = ~(8'd1 << k);
      checks++;
      if (dif.an !== ea || dif.seg !== 8'hFF) begin
        errors++;
        $display("FAIL scan_slot%0d: an=%h seg=%h expected %h FF", k, dif.an, dif.seg, ea);
      end
    end
  endtask

  task automatic test_max;
    int bcount;
    bit ok;
    exp_q.push_back(to_bcd(1048575));
    drive_upd(20'd1048575);
    bcount = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (dif.busy === 1'b1) bcount++;
      else break;
    end
    checks++;
    if (bcount !== 20) begin
      errors++;
      $display("FAIL max_busy_len: got %0d cycles expected 20", bcount);
    end
    checks++;
    if (dif.done !== 1'b1 || dif.digits !== 28'h1048575) begin
      errors++;
      $display("FAIL max_done: done=%b digits=%h expected 1 1048575", dif.done, dif.digits);
    end
    wait_slot(6, ok);
    checks++;
    if (!ok || dif.seg !== 8'hF9) begin
      errors++;
      $display("FAIL max_slot6: found=%0d seg=%h expected F9", ok, dif.seg);
    end
    wait_slot(0, ok);
    checks++;
    if (!ok || dif.seg !== 8'h92) begin
      errors++;
      $display("FAIL max_slot0: found=%0d seg=%h expected 92", ok, dif.seg);
    end
  endtask

  task automatic test_907;
    bit ok;
    logic [7:0] es [8];
    es = '{8'hF8, 8'hC0, 8'h90, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    exp_q.push_back(to_bcd(907));
    drive_upd(20'd907);
    wait_done(ok);
    checks++;
    if (!ok || dif.digits !== 28'h0000907) begin
      errors++;
      $display("FAIL v907_digits: done_seen=%0d digits=%h expected 0000907", ok, dif.digits);
    end
    for (int d = 0; d < 8; d++) begin
      wait_slot(d, ok);
      checks++;
      if (!ok || dif.seg !== es[d]) begin
        errors++;
        $display("FAIL v907_slot%0d: found=%0d seg=%h expected %h", d, ok, dif.seg, es[d]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int n, first, second, drops;
    exp_q.push_back(to_bcd(12));
    @(posedge clk); #1;
    dif.upd = 1'b1; dif.value = 20'd12;
    @(posedge clk); #1;
    dif.upd = 1'b0;
    repeat (4) @(posedge clk); #1;
    dif.upd = 1'b1; dif.value = 20'd34;
    @(posedge clk); #1;
    dif.upd = 1'b0;
    repeat (4) @(posedge clk); #1;
    dif.upd = 1'b1; dif.value = 20'd56;
    @(posedge clk); #1;
    dif.upd = 1'b0;
    exp_q.push_back(to_bcd(56));
    n = 0; first = -1; second = -1; drops = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      n++;
      if (dif.done === 1'b1) begin
        if (first < 0) first = n;
        else begin second = n; break; end
      end
      if (dif.busy !== 1'b1) drops++;
    end
    checks++;
    if (first < 0 || second < 0 || (second - first) !== 20) begin
      errors++;
      $display("FAIL b2b_spacing: first=%0d second=%0d expected gap 20", first, second);
    end
    checks++;
    if (drops !== 0) begin
      errors++;
      $display("FAIL b2b_busy: busy low for %0d cycles expected 0", drops);
    end
  endtask

  task automatic test_reset_mid;
    int base;
    exp_q.push_back(to_bcd(500));
    drive_upd(20'd500);
    repeat (10) @(posedge clk); #1;
    rst = 1'b1;
    #1;
    exp_q.delete();
    checks++;
    if (dif.busy !== 1'b0 || dif.digits !== 28'h0 || dif.an !== 8'hFE || dif.seg !== 8'hC0) begin
      errors++;
      $display("FAIL rstmid_state: busy=%b digits=%h an=%h seg=%h expected 0 0000000 FE C0",
               dif.busy, dif.digits, dif.an, dif.seg);
    end
    @(negedge clk);
    rst = 1'b0;
    base = done_cnt;
    repeat (40) @(negedge clk);
    checks++;
    if (done_cnt !== base || dif.busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_quiet: done pulses=%0d busy=%b expected 0 0", done_cnt - base, dif.busy);
    end
  endtask

  task automatic test_sweep;
    bit ok;
    int timeouts;
    timeouts = 0;
    for (int v = 0; v < 1024; v++) begin
      exp_q.push_back(to_bcd(v));
      drive_upd(20'(v));
      wait_done(ok);
      if (!ok) timeouts++;
    end
    checks++;
    if (timeouts !== 0) begin
      errors++;
      $display("FAIL sweep_timeout: %0d conversions without done expected 0", timeouts);
    end
  endtask

  initial begin
    dif.upd = 1'b0;
    dif.value = '0;
    test_reset;
    test_scan;
    test_max;
    test_907;
    test_back_to_back;
    test_reset_mid;
    test_sweep;
    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d results left expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
